// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the dual-core data-memory arbiter.
// Contents:
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   arb_state_e             : arbiter FSM state encoding
package dmem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_ACK     = 2'd3
  } arb_state_e;

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter_rr_select.sv
// Two-input round-robin grant selector (purely combinational).
// Ports:
//   req0_i, req1_i      : pending requests from core0 / core1
//   rr_i                : favoured core when both requests are pending
//   mask_en_i           : when 1, the core named by mask_owner_i is excluded
//   mask_owner_i        : core to exclude (the owner finishing its access)
//   gnt_valid_o         : a grant is available
//   gnt_id_o            : granted core index
module dmem_arbiter_rr_select (
  input  logic req0_i,
  input  logic req1_i,
  input  logic rr_i,
  input  logic mask_en_i,
  input  logic mask_owner_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);

  logic req0_eff_s;
  logic req1_eff_s;

  // The finishing owner's request is stale during ACK, so it is masked out.
  assign req0_eff_s = req0_i & ~(mask_en_i & ~mask_owner_i);
  assign req1_eff_s = req1_i & ~(mask_en_i &  mask_owner_i);

  // Grant decode: contention resolved by rr_i, otherwise the lone requester.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id_o    = 1'b0;
    if (req0_eff_s && req1_eff_s) begin
      gnt_valid_o = 1'b1;
      gnt_id_o    = rr_i;
    end else if (req0_eff_s) begin
      gnt_valid_o = 1'b1;
      gnt_id_o    = 1'b0;
    end else if (req1_eff_s) begin
      gnt_valid_o = 1'b1;
      gnt_id_o    = 1'b1;
    end else begin
      gnt_valid_o = 1'b0;
      gnt_id_o    = 1'b0;
    end
  end

endmodule : dmem_arbiter_rr_select

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter placing two pipeline cores onto one single-port,
// synchronous-read data memory. Each access takes ISSUE -> CAPTURE -> ACK;
// a waiting core is granted straight from ACK so alternating traffic runs
// at one access per three cycles.
// Ports:
//   Clk, Reset                        : clock, async active-high reset
//   Req*/We*/Addr*/WData*             : core request side (held until Ready*)
//   RData*/Ready*                     : core load data and completion pulse
//   MemEn/MemWe/MemAddr/MemWData      : registered memory command
//   MemRData                          : memory read data (one cycle after MemEn)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              We0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [DATA_W-1:0] WData0,
  output logic [DATA_W-1:0] RData0,
  output logic              Ready0,
  input  logic              Req1,
  input  logic              We1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData1,
  output logic [DATA_W-1:0] RData1,
  output logic              Ready1,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData
);

  arb_state_e        state_q;
  logic              owner_q;
  logic              rr_q;
  logic              we_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              ready0_q;
  logic              ready1_q;

  logic              gnt_valid_s;
  logic              gnt_id_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              in_ack_s;

  assign in_ack_s = (state_q == S_ACK);

  dmem_arbiter_rr_select u_rr_select (
    .req0_i       (Req0),
    .req1_i       (Req1),
    .rr_i         (rr_q),
    .mask_en_i    (in_ack_s),
    .mask_owner_i (owner_q),
    .gnt_valid_o  (gnt_valid_s),
    .gnt_id_o     (gnt_id_s)
  );

  // Route the granted core's request fields toward the command registers.
  always_comb begin
    sel_we_s    = We0;
    sel_addr_s  = Addr0;
    sel_wdata_s = WData0;
    if (gnt_id_s) begin
      sel_we_s    = We1;
      sel_addr_s  = Addr1;
      sel_wdata_s = WData1;
    end else begin
      sel_we_s    = We0;
      sel_addr_s  = Addr0;
      sel_wdata_s = WData0;
    end
  end

  // Arbiter FSM with all core- and memory-facing outputs registered.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      rr_q        <= 1'b0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      rdata0_q    <= {DATA_W{1'b0}};
      rdata1_q    <= {DATA_W{1'b0}};
      ready0_q    <= 1'b0;
      ready1_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_valid_s) begin
            owner_q     <= gnt_id_s;
            we_q        <= sel_we_s;
            mem_en_q    <= 1'b1;
            mem_we_q    <= sel_we_s;
            mem_addr_q  <= sel_addr_s;
            mem_wdata_q <= sel_wdata_s;
            state_q     <= S_ISSUE;
          end else begin
            state_q     <= S_IDLE;
          end
        end
        S_ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          state_q  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // MemRData is valid now, one cycle after the strobe.
          if (!we_q) begin
            if (owner_q) begin
              rdata1_q <= MemRData;
            end else begin
              rdata0_q <= MemRData;
            end
          end else begin
            rdata0_q <= rdata0_q;
          end
          ready0_q <= ~owner_q;
          ready1_q <=  owner_q;
          state_q  <= S_ACK;
        end
        S_ACK: begin
          ready0_q <= 1'b0;
          ready1_q <= 1'b0;
          rr_q     <= ~owner_q;
          // Only the non-owner can win here; serving it directly skips IDLE.
          if (gnt_valid_s) begin
            owner_q     <= gnt_id_s;
            we_q        <= sel_we_s;
            mem_en_q    <= 1'b1;
            mem_we_q    <= sel_we_s;
            mem_addr_q  <= sel_addr_s;
            mem_wdata_q <= sel_wdata_s;
            state_q     <= S_ISSUE;
          end else begin
            state_q     <= S_IDLE;
          end
        end
        default: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          ready0_q <= 1'b0;
          ready1_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign MemEn    = mem_en_q;
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign RData0   = rdata0_q;
  assign RData1   = rdata1_q;
  assign Ready0   = ready0_q;
  assign Ready1   = ready1_q;

endmodule : dmem_arbiter
